// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
//   Direct-mapped, write-through, no-write-allocate cache front-end.
//   The cache has 8 lines of 4 bytes. Each line has a 3-bit tag and a valid bit.
//   A read miss fills the line from a main memory with a registered read port.
//
// Ports
//   clk, rst_n            clock and asynchronous active-low reset
//   cpu_req/cpu_we        CPU request strobe and write select
//   cpu_addr/cpu_wdata    CPU byte address (tag[7:5] idx[4:2] off[1:0]), write byte
//   inv                   invalidate-all request, honoured only in IDLE
//   cpu_ready             request may be accepted this cycle
//   cpu_done/cpu_hit      one-cycle completion pulse and its hit flag
//   cpu_rdata             read result, valid with cpu_done on reads
//   mem_we/mem_addr/mem_wdata/mem_rdata   main-memory port
//   hit_count/miss_count  saturating access statistics
// -----------------------------------------------------------------------------
module cache_controller #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              inv,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_we,
  output logic [7:0]        mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPARE = 3'd1,
    FILL    = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  state_t      state_r;
  state_t      state_s;

  logic        we_r;
  logic [7:0]  addr_r;
  logic [7:0]  wdata_r;
  logic        hit_r;
  logic [2:0]  c_r;

  logic [7:0]  valid_r;
  logic [2:0]  tag_r  [0:7];
  logic [7:0]  data_r [0:31];

  logic [2:0]  idx_s;
  logic        hit_s;
  logic        accept_s;
  logic [1:0]  fill_off_s;

  assign idx_s      = addr_r[4:2];
  assign hit_s      = valid_r[idx_s] && (tag_r[idx_s] == addr_r[7:5]);
  assign cpu_ready  = (state_r == IDLE) && !inv;
  assign accept_s   = cpu_req && cpu_ready;
  // Byte captured at the end of fill cycle c is byte c-1. For c=4 this wraps to 3.
  assign fill_off_s = c_r[1:0] - 2'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = COMPARE;
        end else begin
          state_s = IDLE;
        end
      end
      COMPARE: begin
        if (we_r) begin
          state_s = WRITE;
        end else if (hit_s) begin
          state_s = RESP;
        end else begin
          state_s = FILL;
        end
      end
      FILL: begin
        if (c_r == 3'd4) begin
          state_s = RESP;
        end else begin
          state_s = FILL;
        end
      end
      WRITE:   state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Request latches, hit flag and fill counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      addr_r  <= 8'h00;
      wdata_r <= 8'h00;
      hit_r   <= 1'b0;
      c_r     <= 3'd0;
    end else begin
      if (accept_s) begin
        we_r    <= cpu_we;
        addr_r  <= cpu_addr;
        wdata_r <= cpu_wdata;
      end
      if (state_r == COMPARE) begin
        hit_r <= hit_s;
      end
      if (state_r == FILL) begin
        c_r <= (c_r == 3'd4) ? 3'd0 : c_r + 3'd1;
      end
    end
  end

  // Valid bits. A line becomes valid only once the fill completes, so a
  // reset during a fill leaves the line invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 8'h00;
    end else if ((state_r == IDLE) && inv) begin
      valid_r <= 8'h00;
    end else if ((state_r == FILL) && (c_r == 3'd4)) begin
      valid_r[idx_s] <= 1'b1;
    end
  end

  // Hit/miss statistics, updated once per access in COMPARE and saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= {STAT_W{1'b0}};
      miss_count <= {STAT_W{1'b0}};
    end else if (state_r == COMPARE) begin
      if (hit_s) begin
        if (hit_count != STAT_MAX) begin
          hit_count <= hit_count + STAT_ONE;
        end
      end else begin
        if (miss_count != STAT_MAX) begin
          miss_count <= miss_count + STAT_ONE;
        end
      end
    end
  end

  // Line data and tags. These are not reset because validity gates their use.
  always_ff @(posedge clk) begin
    if ((state_r == FILL) && (c_r != 3'd0)) begin
      data_r[{idx_s, fill_off_s}] <= mem_rdata;
      if (c_r == 3'd4) begin
        tag_r[idx_s] <= addr_r[7:5];
      end
    end else if ((state_r == WRITE) && hit_r) begin
      data_r[addr_r[4:0]] <= wdata_r;
    end
  end

  // Moore output decode from state and latched request
  always_comb begin
    cpu_done  = 1'b0;
    cpu_hit   = 1'b0;
    cpu_rdata = 8'h00;
    mem_we    = 1'b0;
    mem_addr  = addr_r;
    mem_wdata = wdata_r;
    case (state_r)
      FILL: begin
        mem_addr = {addr_r[7:2], c_r[1:0]};
      end
      WRITE: begin
        mem_we = 1'b1;
      end
      RESP: begin
        cpu_done = 1'b1;
        cpu_hit  = hit_r;
        if (we_r) begin
          cpu_rdata = 8'h00;
        end else begin
          cpu_rdata = data_r[addr_r[4:0]];
        end
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        inv;
  logic        cpu_ready;
  logic        cpu_done;
  logic [7:0]  cpu_rdata;
  logic        cpu_hit;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  cache_controller #(.STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .inv(inv),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .cpu_hit(cpu_hit), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       hit;
    int         lat;
    int         a;
    int         hits;
    int         miss;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mem [0:255];
  int          cyc;
  int          n_chk;
  int          n_pass;
  int          exp_hits;
  int          exp_miss;
  int          we_cnt;
  logic [7:0]  we_addr;
  logic [7:0]  we_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];
  end

  // Main memory with a registered read port and write-through store
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals completion
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_we) begin
        we_cnt  = we_cnt + 1;
        we_addr = mem_addr;
        we_data = mem_wdata;
      end
      if (cpu_done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", int'(cpu_done), 0);
        end else begin
          e = q.pop_front();
          chk("rdata", int'(cpu_rdata), int'(e.rdata));
          chk("hit", int'(cpu_hit), int'(e.hit));
          chk("latency", cyc - e.a, e.lat);
          chk("hit_count", int'(hit_count), e.hits);
          chk("miss_count", int'(miss_count), e.miss);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                       input logic [7:0] rdata_exp, input logic hit_exp, input int lat);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!cpu_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(cpu_ready), 1);
    if (hit_exp) exp_hits++; else exp_miss++;
    e.rdata = rdata_exp; e.hit = hit_exp; e.lat = lat; e.a = cyc;
    e.hits = exp_hits;   e.miss = exp_miss;
    q.push_back(e);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk);
    #1 cpu_req = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", q.size(), 0);
    q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_done"},  int'(cpu_done), 0);
    chk({tag, "_hit"},   int'(cpu_hit), 0);
    chk({tag, "_rdata"}, int'(cpu_rdata), 0);
    chk({tag, "_mwe"},   int'(mem_we), 0);
    chk({tag, "_maddr"}, int'(mem_addr), 0);
    chk({tag, "_mwdat"}, int'(mem_wdata), 0);
    chk({tag, "_hits"},  int'(hit_count), 0);
    chk({tag, "_miss"},  int'(miss_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int w0;
    cyc = 0; n_chk = 0; n_pass = 0; exp_hits = 0; exp_miss = 0; we_cnt = 0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00; inv = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2 chk("ready_after_reset", int'(cpu_ready), 1);

    // Read 0x25: miss, fill 0x24..0x27 in A+2..A+5
    issue(1'b0, 8'h25, 8'h00, 8'h25, 1'b0, 7);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #2 chk("fill_addr", int'(mem_addr), 8'h24 + k);
    end
    wait_done();

    // Read 0x26: hit
    issue(1'b0, 8'h26, 8'h00, 8'h26, 1'b1, 2);
    wait_done();

    // Write hit 0x26 = 0xAB, then read back
    w0 = we_cnt;
    issue(1'b1, 8'h26, 8'hAB, 8'h00, 1'b1, 3);
    wait_done();
    chk("wr_hit_we_cycles", we_cnt - w0, 1);
    chk("wr_hit_addr", int'(we_addr), 8'h26);
    chk("wr_hit_data", int'(we_data), 8'hAB);
    issue(1'b0, 8'h26, 8'h00, 8'hAB, 1'b1, 2);
    wait_done();

    // Conflict miss evicts index 1, then re-miss on 0x25
    issue(1'b0, 8'hA5, 8'h00, 8'hA5, 1'b0, 7);
    wait_done();
    issue(1'b0, 8'h25, 8'h00, 8'h25, 1'b0, 7);
    wait_done();

    // Write miss 0x40 = 0x5A: no allocate, then read misses and sees memory
    w0 = we_cnt;
    issue(1'b1, 8'h40, 8'h5A, 8'h00, 1'b0, 3);
    wait_done();
    chk("wr_miss_we_cycles", we_cnt - w0, 1);
    chk("wr_miss_addr", int'(we_addr), 8'h40);
    chk("wr_miss_data", int'(we_data), 8'h5A);
    issue(1'b0, 8'h40, 8'h00, 8'h5A, 1'b0, 7);
    wait_done();

    // Invalidate together with a request: request ignored
    @(negedge clk);
    inv = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h25;
    #1 chk("ready_during_inv", int'(cpu_ready), 0);
    @(posedge clk);
    #1 inv = 1'b0; cpu_req = 1'b0;
    #1 chk("ready_after_inv", int'(cpu_ready), 1);
    issue(1'b0, 8'h25, 8'h00, 8'h25, 1'b0, 7);
    wait_done();

    // Reset during FILL c=2
    issue(1'b0, 8'h65, 8'h00, 8'h65, 1'b0, 7);
    repeat (3) @(posedge clk);
    #2 chk("fill_c2_addr", int'(mem_addr), 8'h66);
    rst_n = 1'b0;
    #1 check_reset_outputs("midfill");
    chk("midfill_ready", int'(cpu_ready), 1);
    q.delete();
    exp_hits = 0; exp_miss = 0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 8'h65, 8'h00, 8'h65, 1'b0, 7);
    wait_done();
    issue(1'b0, 8'h65, 8'h00, 8'h65, 1'b1, 2);
    wait_done();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
